// File: rtl/mtr_drv_pwm_if.sv
// Motor driver PWM bus: signed speed commands in, H-bridge legs and period strobe out.
// master drives lft_spd/rght_spd; slave (mtr_drv_pwm) drives the bridge legs and period_strt.
interface mtr_drv_pwm_if;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lftPWM1;
    logic        lftPWM2;
    logic        rghtPWM1;
    logic        rghtPWM2;
    logic        period_strt;

    modport master (
        output lft_spd,
        output rght_spd,
        input  lftPWM1,
        input  lftPWM2,
        input  rghtPWM1,
        input  rghtPWM2,
        input  period_strt
    );

    modport slave (
        input  lft_spd,
        input  rght_spd,
        output lftPWM1,
        output lftPWM2,
        output rghtPWM1,
        output rghtPWM2,
        output period_strt
    );
endinterface

// File: rtl/mtr_drv_pwm.sv
// Sign-magnitude PWM driver for two H-bridges with glitch-free period-boundary updates.
// Ports: clk, rst (sync active-high), bus (slave: lft_spd/rght_spd in; legs + period_strt out).
module mtr_drv_pwm #(
    parameter int CNT_W    = 10,
    parameter int DEAD_PER = 1
) (
    input  logic         clk,
    input  logic         rst,
    mtr_drv_pwm_if.slave bus
);

    localparam int DW = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        FWD  = 2'd0,
        REV  = 2'd1,
        DEAD = 2'd2
    } side_st_t;

    logic [CNT_W-1:0] cnt;
    logic             smp;
    logic             pstrt;
    logic [10:0]      spd [2];
    logic [1:0]       pwm1;
    logic [1:0]       pwm2;

    assign spd[0] = bus.lft_spd;
    assign spd[1] = bus.rght_spd;

    // The last count of a period is the only cycle inputs are looked at,
    // so new duty/direction take effect exactly at the next cnt==0.
    assign smp = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            pstrt <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
            pstrt <= (cnt == '0);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_side
        logic [10:0]      neg;
        logic [9:0]       mag;
        logic             dir_s;
        logic [CNT_W-1:0] duty;
        logic [DW-1:0]    dcnt;
        side_st_t         st;
        logic             p1;
        logic             p2;

        // -0x400 has no positive 11-bit form; clamp it to full scale.
        always_comb begin
            neg   = -spd[g];
            dir_s = spd[g][10];
            mag   = spd[g][9:0];
            if (dir_s) begin
                mag = neg[10] ? 10'h3FF : neg[9:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st   <= FWD;
                duty <= '0;
                dcnt <= '0;
                p1   <= 1'b0;
                p2   <= 1'b0;
            end else begin
                p1 <= (st == FWD) && (cnt < duty);
                p2 <= (st == REV) && (cnt < duty);
                if (smp) begin
                    duty <= CNT_W'(mag);
                    unique case (st)
                        FWD: begin
                            if ((mag != '0) && dir_s) begin
                                st   <= DEAD;
                                dcnt <= DW'(DEAD_PER - 1);
                            end
                        end
                        REV: begin
                            if ((mag != '0) && !dir_s) begin
                                st   <= DEAD;
                                dcnt <= DW'(DEAD_PER - 1);
                            end
                        end
                        DEAD: begin
                            // Leave toward whatever is asked now, so a
                            // request that flipped back cancels the reversal.
                            if (dcnt != '0) begin
                                dcnt <= dcnt - 1'b1;
                            end else begin
                                st <= dir_s ? REV : FWD;
                            end
                        end
                        default: begin
                            st <= FWD;
                        end
                    endcase
                end
            end
        end

        assign pwm1[g] = p1;
        assign pwm2[g] = p2;
    end

    assign bus.lftPWM1     = pwm1[0];
    assign bus.lftPWM2     = pwm2[0];
    assign bus.rghtPWM1    = pwm1[1];
    assign bus.rghtPWM2    = pwm2[1];
    assign bus.period_strt = pstrt;

    a_no_shoot_l : assert property (@(posedge clk) !(pwm1[0] && pwm2[0]));
    a_no_shoot_r : assert property (@(posedge clk) !(pwm1[1] && pwm2[1]));

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: directed scenarios plus random speeds vs a per-cycle reference model.
// Ports exercised: clk, rst, full mtr_drv_pwm_if bus.
module tb_mtr_drv_pwm;

    localparam int PER = 1024;
    localparam int DP  = 1;
    localparam int M_FWD  = 0;
    localparam int M_REV  = 1;
    localparam int M_DEAD = 2;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    int m_cnt;
    int m_duty [2];
    int m_mode [2];
    int m_dead [2];

    mtr_drv_pwm_if bus ();

    mtr_drv_pwm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mag_of(input logic [10:0] s);
        int v;
        v = s[10] ? int'(s) - 2048 : int'(s);
        if (v < 0) v = -v;
        if (v > PER - 1) v = PER - 1;
        return v;
    endfunction

    // One clock: advance the model by one edge, then compare all outputs.
    task automatic tick();
        logic [4:0]  e;
        logic [10:0] sp [2];
        int          mg;
        bit          rv;
        @(posedge clk);
        sp[0] = bus.lft_spd;
        sp[1] = bus.rght_spd;
        e = '0;
        if (rst) begin
            m_cnt = 0;
            for (int s = 0; s < 2; s++) begin
                m_duty[s] = 0;
                m_mode[s] = M_FWD;
                m_dead[s] = 0;
            end
        end else begin
            e[4] = (m_cnt == 0);
            for (int s = 0; s < 2; s++) begin
                e[3-2*s] = (m_mode[s] == M_FWD) && (m_cnt < m_duty[s]);
                e[2-2*s] = (m_mode[s] == M_REV) && (m_cnt < m_duty[s]);
            end
            if (m_cnt == PER - 1) begin
                for (int s = 0; s < 2; s++) begin
                    mg = mag_of(sp[s]);
                    rv = sp[s][10];
                    m_duty[s] = mg;
                    if (m_mode[s] == M_DEAD) begin
                        if (m_dead[s] > 0) m_dead[s]--;
                        else m_mode[s] = rv ? M_REV : M_FWD;
                    end else if (mg != 0 && (rv != (m_mode[s] == M_REV))) begin
                        m_mode[s] = M_DEAD;
                        m_dead[s] = DP - 1;
                    end
                end
            end
            m_cnt = (m_cnt + 1) % PER;
        end
        #1;
        chk("outs", {bus.period_strt, bus.lftPWM1, bus.lftPWM2,
                     bus.rghtPWM1, bus.rghtPWM2}, 32'(e));
        chk("shoot", 32'((bus.lftPWM1 & bus.lftPWM2) |
                         (bus.rghtPWM1 & bus.rghtPWM2)), 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int c);
        int k;
        k = 0;
        while (m_cnt != c && k < 2 * PER) begin
            tick();
            k++;
        end
    endtask

    function automatic logic [10:0] pick();
        logic [10:0] v;
        case ($urandom_range(0, 7))
            0:       v = 11'h000;
            1:       v = 11'h3FF;
            2:       v = 11'h400;
            3:       v = 11'h7FF;
            4:       v = 11'h001;
            default: v = 11'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int r;
        n_chk  = 0;
        n_fail = 0;
        m_cnt  = 0;
        rst    = 1'b1;
        bus.lft_spd  = '0;
        bus.rght_spd = '0;
        for (int s = 0; s < 2; s++) begin
            m_duty[s] = 0;
            m_mode[s] = M_FWD;
            m_dead[s] = 0;
        end

        run(3);
        rst = 1'b0;
        tick();
        chk("pstrt_rel", 32'(bus.period_strt), 32'd1);

        bus.lft_spd = 11'h200;
        run(3 * PER);

        bus.lft_spd = 11'h3FF;
        run(2 * PER);
        bus.lft_spd = 11'h000;
        run(3 * PER);

        bus.rght_spd = 11'h100;
        run(2 * PER);
        bus.rght_spd = 11'h400;
        run(3 * PER);

        bus.lft_spd = 11'h200;
        run_to(500);
        run(PER);
        bus.lft_spd = 11'h7FF;
        run(PER);
        bus.lft_spd = 11'h200;
        run(3 * PER);

        run_to(300);
        bus.lft_spd = 11'h123;
        run(2 * PER);

        bus.lft_spd = 11'h200;
        run(PER);
        run_to(100);
        chk("pre_rst_l1", 32'(bus.lftPWM1), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_l1", 32'(bus.lftPWM1), 32'd0);
        run(2);
        rst = 1'b0;
        tick();
        chk("pstrt_rel2", 32'(bus.period_strt), 32'd1);
        run(PER);

        for (int p = 0; p < 25; p++) begin
            r = $urandom_range(1, PER - 1);
            run(r);
            bus.lft_spd  = pick();
            bus.rght_spd = pick();
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                run(2);
                rst = 1'b0;
            end
            run(PER - r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
